pkg_gen: RTL and testbench

- Packet transmitter that drives the 512-bit packet stream consumed by the packet processor: the sender end of the same stream interface.
- Emits a programmable number of packets with a programmable length and inter-packet idle gap.
- Each packet carries a header beat with sequence number, send timestamp and queue id, so the receiver can measure gaps and timeouts.
- Sits between the host control registers and the packet-processor input in the test/measurement datapath.

---
 rtl/pkg_gen_if.sv | 27 ++
 rtl/pkg_gen.sv | 148 ++++++++++++++
 tb/tb_pkg_gen.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pkg_gen_if.sv
// Packet stream bundle between a packet sender and its consumer.
// The master drives beats, the slave answers with ready.
interface pkg_gen_if #(
  parameter int DATA_W = 512
);
  logic                  io_data_out_valid;
  logic                  io_data_out_ready;
  logic [DATA_W-1:0]     io_data_out_bits_data;
  logic [DATA_W/8-1:0]   io_data_out_bits_keep;
  logic                  io_data_out_bits_last;

  modport master (
    output io_data_out_valid,
    output io_data_out_bits_data,
    output io_data_out_bits_keep,
    output io_data_out_bits_last,
    input  io_data_out_ready
  );

  modport slave (
    input  io_data_out_valid,
    input  io_data_out_bits_data,
    input  io_data_out_bits_keep,
    input  io_data_out_bits_last,
    output io_data_out_ready
  );
endinterface

// File: rtl/pkg_gen.sv
// Packet generator: emits runs of fixed-length packets with a header beat
// (seq, send timestamp, queue id) and a programmable idle gap between packets.
module pkg_gen #(
  parameter int DATA_W = 512,
  parameter int TS_W   = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_start,
  input  logic [31:0] io_pkg_num,
  input  logic [15:0] io_pkg_len,
  input  logic [31:0] io_idle_cycle,
  input  logic [23:0] io_qp_id,
  pkg_gen_if.master   data_out,
  output logic        io_busy,
  output logic        io_done,
  output logic [31:0] io_sent_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [TS_W-1:0]   ts_q;
  logic [31:0]       seq_q, seq_d;
  logic [31:0]       sent_q, sent_d;
  logic [31:0]       gap_q, gap_d;
  logic [15:0]       beat_q, beat_d;

  logic [31:0]       num_q, idle_q;
  logic [15:0]       len_q;
  logic [23:0]       qp_q;
  logic [TS_W-1:0]   hts_q;

  logic              cfg_load, hdr_load;
  logic              last_beat, fire;
  logic [DATA_W-1:0] data_o;

  assign last_beat = (beat_q == 16'(len_q - 16'd1));
  assign fire      = (state_q == S_SEND) && data_out.io_data_out_ready;

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    sent_d   = sent_q;
    gap_d    = gap_q;
    beat_d   = beat_q;
    cfg_load = 1'b0;
    hdr_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io_start) begin
          if (io_pkg_num == 32'd0) begin
            state_d = S_DONE;
          end else begin
            cfg_load = 1'b1;
            hdr_load = 1'b1;
            sent_d   = 32'd0;
            seq_d    = 32'd0;
            beat_d   = 16'd0;
            state_d  = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (fire) begin
          if (!last_beat) begin
            beat_d = beat_q + 16'd1;
          end else begin
            sent_d = sent_q + 32'd1;
            seq_d  = seq_q + 32'd1;
            beat_d = 16'd0;
            if (sent_q + 32'd1 == num_q) begin
              state_d = S_DONE;
            end else if (idle_q == 32'd0) begin
              hdr_load = 1'b1;
            end else begin
              gap_d   = idle_q;
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q <= 32'd1) begin
          hdr_load = 1'b1;
          state_d  = S_SEND;
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ts_q    <= '0;
      seq_q   <= 32'd0;
      sent_q  <= 32'd0;
      gap_q   <= 32'd0;
      beat_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + TS_W'(1);
      seq_q   <= seq_d;
      sent_q  <= sent_d;
      gap_q   <= gap_d;
      beat_q  <= beat_d;
    end
  end

  // Header timestamp is captured one cycle early as ts+1, i.e. the value seen
  // in the cycle the header first becomes valid, and then held through stalls.
  always_ff @(posedge clock) begin
    if (cfg_load) begin
      num_q  <= io_pkg_num;
      len_q  <= (io_pkg_len == 16'd0) ? 16'd1 : io_pkg_len;
      idle_q <= io_idle_cycle;
      qp_q   <= io_qp_id;
    end
    if (hdr_load) hts_q <= ts_q + TS_W'(1);
  end

  always_comb begin
    data_o = '0;
    if (state_q == S_SEND) begin
      data_o[31:0] = seq_q;
      if (beat_q == 16'd0) begin
        data_o[63:32]  = 32'(hts_q);
        data_o[87:64]  = qp_q;
        data_o[103:88] = len_q;
      end else begin
        data_o[47:32] = beat_q;
      end
    end
  end

  assign data_out.io_data_out_valid     = (state_q == S_SEND);
  assign data_out.io_data_out_bits_data = data_o;
  assign data_out.io_data_out_bits_keep = '1;
  assign data_out.io_data_out_bits_last = (state_q == S_SEND) && last_beat;
  assign io_busy     = (state_q != S_IDLE);
  assign io_done     = (state_q == S_DONE);
  assign io_sent_cnt = sent_q;

endmodule

// File: tb/tb_pkg_gen.sv
// Scoreboard bench for pkg_gen: expected beats are queued at start and
// compared as the generator emits them; control timing is checked per cycle.
module tb_pkg_gen;
  localparam int DATA_W = 512;

  typedef struct {
    logic [31:0] seq;
    logic [15:0] beat;
    logic [15:0] len;
    logic [23:0] qp;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pkg_num;
  logic [15:0] pkg_len;
  logic [31:0] idle_cyc;
  logic [23:0] qp_id;
  logic        busy, done;
  logic [31:0] sent;

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;
  logic [31:0] tb_ts;
  beat_t sb[$];

  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] held_data;
  logic              held_last;

  pkg_gen_if #(.DATA_W(DATA_W)) dif ();

  pkg_gen #(.DATA_W(DATA_W), .TS_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_start     (start),
    .io_pkg_num   (pkg_num),
    .io_pkg_len   (pkg_len),
    .io_idle_cycle(idle_cyc),
    .io_qp_id     (qp_id),
    .data_out     (dif),
    .io_busy      (busy),
    .io_done      (done),
    .io_sent_cnt  (sent)
  );

  always #5 clock = ~clock;

  // Reference free-running timestamp: cleared by reset, +1 per clock.
  always @(posedge clock or posedge reset) begin
    if (reset) tb_ts <= 32'd0;
    else       tb_ts <= tb_ts + 32'd1;
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_data(input beat_t e, input logic [31:0] ts);
    logic [DATA_W-1:0] d;
    d = '0;
    d[31:0] = e.seq;
    if (e.beat == 16'd0) begin
      d[63:32]  = ts;
      d[87:64]  = e.qp;
      d[103:88] = e.len;
    end else begin
      d[47:32] = e.beat;
    end
    return d;
  endfunction

  // Stream monitor: new beats are popped from the scoreboard, stalled beats
  // must repeat exactly, and a stalled beat may not be withdrawn.
  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else if (dif.io_data_out_valid) begin
      if (stall_prev) begin
        chk("stable_data", dif.io_data_out_bits_data, held_data);
        chk("stable_last", DATA_W'(dif.io_data_out_bits_last), DATA_W'(held_last));
      end else begin
        chk("sb_nonempty", DATA_W'(sb.size() > 0), DATA_W'(1));
        if (sb.size() > 0) begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_data", dif.io_data_out_bits_data, exp_data(e, tb_ts));
          chk("beat_last", DATA_W'(dif.io_data_out_bits_last), DATA_W'(e.beat == e.len - 16'd1));
          chk("beat_keep", DATA_W'(dif.io_data_out_bits_keep), DATA_W'({(DATA_W/8){1'b1}}));
        end
      end
      held_data  = dif.io_data_out_bits_data;
      held_last  = dif.io_data_out_bits_last;
      stall_prev = !dif.io_data_out_ready;
      if (dif.io_data_out_ready) hs_cnt++;
    end else begin
      if (stall_prev) chk("valid_held", DATA_W'(dif.io_data_out_valid), DATA_W'(1));
      stall_prev = 1'b0;
    end
  end

  task automatic push_run(input int num, input int len, input logic [23:0] qp);
    int le;
    le = (len == 0) ? 1 : len;
    for (int p = 0; p < num; p++)
      for (int b = 0; b < le; b++)
        sb.push_back('{seq: 32'(p), beat: 16'(b), len: 16'(le), qp: qp});
  endtask

  // Called just after a clock edge; returns just after the edge that samples start.
  task automatic start_run(input int num, input int len, input int idle, input logic [23:0] qp);
    push_run(num, len, qp);
    pkg_num  = 32'(num);
    pkg_len  = 16'(len);
    idle_cyc = 32'(idle);
    qp_id    = qp;
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic expect_cycle(input string tag, input logic v, input logic d, input logic b);
    @(negedge clock);
    chk({tag, "_valid"}, DATA_W'(dif.io_data_out_valid), DATA_W'(v));
    chk({tag, "_done"},  DATA_W'(done), DATA_W'(d));
    chk({tag, "_busy"},  DATA_W'(busy), DATA_W'(b));
    @(posedge clock); #1;
  endtask

  task automatic wait_done(input string tag, input int budget, input logic toggle);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
      @(posedge clock); #1;
      if (toggle) dif.io_data_out_ready = !dif.io_data_out_ready;
    end
    chk({tag, "_done_seen"}, DATA_W'(seen), DATA_W'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0; pkg_num = '0; pkg_len = '0; idle_cyc = '0; qp_id = '0;
    dif.io_data_out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", DATA_W'(dif.io_data_out_valid), DATA_W'(0));
    chk("rst_last",  DATA_W'(dif.io_data_out_bits_last), DATA_W'(0));
    chk("rst_data",  dif.io_data_out_bits_data, '0);
    chk("rst_busy",  DATA_W'(busy), DATA_W'(0));
    chk("rst_done",  DATA_W'(done), DATA_W'(0));
    chk("rst_sent",  DATA_W'(sent), DATA_W'(0));
    reset = 1'b0;
    @(posedge clock); #1;

    // Back-to-back header-only packets.
    start_run(5, 1, 0, 24'h123456);
    for (int i = 0; i < 5; i++) expect_cycle("t1_beat", 1'b1, 1'b0, 1'b1);
    expect_cycle("t1_done", 1'b0, 1'b1, 1'b1);
    expect_cycle("t1_idle", 1'b0, 1'b0, 1'b0);
    chk("t1_sent", DATA_W'(sent), DATA_W'(5));
    chk("t1_sb_empty", DATA_W'(sb.size()), DATA_W'(0));

    // Multi-beat packets separated by a 4-cycle gap.
    start_run(2, 3, 4, 24'h0000A5);
    for (int i = 0; i < 3; i++) expect_cycle("t2_p0", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) expect_cycle("t2_gap", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) expect_cycle("t2_p1", 1'b1, 1'b0, 1'b1);
    expect_cycle("t2_done", 1'b0, 1'b1, 1'b1);
    expect_cycle("t2_idle", 1'b0, 1'b0, 1'b0);
    chk("t2_sent", DATA_W'(sent), DATA_W'(2));
    chk("t2_sb_empty", DATA_W'(sb.size()), DATA_W'(0));

    // Ready toggling every cycle: beats must hold through stalls.
    hs_cnt = 0;
    start_run(3, 2, 0, 24'h00BEEF);
    wait_done("t3", 60, 1'b1);
    dif.io_data_out_ready = 1'b1;
    chk("t3_handshakes", DATA_W'(hs_cnt), DATA_W'(6));
    chk("t3_sent", DATA_W'(sent), DATA_W'(3));
    chk("t3_sb_empty", DATA_W'(sb.size()), DATA_W'(0));

    // Zero-packet run: done one cycle after start, busy for that cycle only.
    start_run(0, 4, 0, 24'h111111);
    expect_cycle("t4_zero", 1'b0, 1'b1, 1'b1);
    expect_cycle("t4_after", 1'b0, 1'b0, 1'b0);
    chk("t4_sent_kept", DATA_W'(sent), DATA_W'(3));

    // A start during a run must not disturb it.
    start_run(2, 2, 1, 24'h222222);
    @(posedge clock); #1;
    pkg_num = 32'd9; pkg_len = 16'd5; idle_cyc = 32'd0; qp_id = 24'h999999;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("t4b", 40, 1'b0);
    chk("t4b_sent", DATA_W'(sent), DATA_W'(2));
    chk("t4b_sb_empty", DATA_W'(sb.size()), DATA_W'(0));
    expect_cycle("t4b_idle", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while beat 1 of 4 is stalled.
    start_run(1, 4, 0, 24'h333333);
    @(posedge clock); #1;
    dif.io_data_out_ready = 1'b0;
    @(negedge clock);
    chk("t5_pre_valid", DATA_W'(dif.io_data_out_valid), DATA_W'(1));
    #2 reset = 1'b1;
    #1;
    chk("t5_async_valid", DATA_W'(dif.io_data_out_valid), DATA_W'(0));
    chk("t5_async_busy", DATA_W'(busy), DATA_W'(0));
    chk("t5_async_sent", DATA_W'(sent), DATA_W'(0));
    sb.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    dif.io_data_out_ready = 1'b1;
    @(posedge clock); #1;
    start_run(1, 1, 0, 24'hABCDEF);
    expect_cycle("t5_hdr", 1'b1, 1'b0, 1'b1);
    expect_cycle("t5_done", 1'b0, 1'b1, 1'b1);
    chk("t5_sent", DATA_W'(sent), DATA_W'(1));
    chk("t5_sb_empty", DATA_W'(sb.size()), DATA_W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
